// File: rtl/multiword_cla_adder_seq_pkg.sv
// Shared definitions for the multi-word streaming adder.
//   WORD_W  : width of one operand/sum word (matches carry_lookahead_adder_64)
//   state_e : operation state (IDLE between operations, RUN inside one)
// Optional feature macro: MULTIWORD_CLA_ADDER_SEQ_SUB_EN (see top module).
package multiword_adder_pkg;
    localparam int WORD_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/multiword_cla_adder_seq_if.sv
// Beat-level handshake bundle for multiword_cla_adder_seq.
//   in_valid/in_ready/in_first/in_last/a/b/cin : operand stream (LS word first)
//   out_valid/out_ready/sum/out_last/cout       : sum stream, one entry deep
//   err                                         : one-cycle protocol-error pulse
//   op_sub                                      : only with MULTIWORD_CLA_ADDER_SEQ_SUB_EN
// slave = the adder, master = producer/consumer side.
interface multiword_cla_adder_seq_if;
    import multiword_adder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic              in_last;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] sum;
    logic              out_last;
    logic              cout;
    logic              err;
`ifdef MULTIWORD_CLA_ADDER_SEQ_SUB_EN
    logic              op_sub;

    modport slave (
        input  in_valid, in_first, in_last, a, b, cin, out_ready, op_sub,
        output in_ready, out_valid, sum, out_last, cout, err
    );
    modport master (
        output in_valid, in_first, in_last, a, b, cin, out_ready, op_sub,
        input  in_ready, out_valid, sum, out_last, cout, err
    );
`else
    modport slave (
        input  in_valid, in_first, in_last, a, b, cin, out_ready,
        output in_ready, out_valid, sum, out_last, cout, err
    );
    modport master (
        output in_valid, in_first, in_last, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, out_last, cout, err
    );
`endif
endinterface

// File: rtl/carry_lookahead_adder_64.sv
// 64-bit combinational adder: 4-bit lookahead groups, group carries chained.
//   a, b : operands      cin  : carry-in
//   sum  : a+b+cin mod 2^64   cout : carry-out
module carry_lookahead_adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [63:0] p;
    logic [63:0] g;
    logic [15:0] grp_p;
    logic [15:0] grp_g;

    always_comb begin
        p = a ^ b;
        g = a & b;
        for (int k = 0; k < 16; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Local running carries keep the chain free of self-referencing signals.
    always_comb begin
        logic cg;
        logic cb;
        sum = '0;
        cg  = cin;
        for (int k = 0; k < 16; k++) begin
            cb = cg;
            for (int i = 0; i < 4; i++) begin
                sum[4*k+i] = p[4*k+i] ^ cb;
                cb = g[4*k+i] | (p[4*k+i] & cb);
            end
            cg = grp_g[k] | (grp_p[k] & cg);
        end
        cout = cg;
    end
endmodule

// File: rtl/multiword_cla_adder_seq.sv
// Streams N x 64-bit operands one word per beat (LS word first) through a
// single carry_lookahead_adder_64, chaining the carry in a register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : multiword_cla_adder_seq_if.slave (operand in, sum out, err)
// Parameter MAX_WORDS bounds an operation; the beat reaching it without
// in_last is forced out as the last word and flagged with err.
// Macro MULTIWORD_CLA_ADDER_SEQ_SUB_EN adds op_sub (A - B via A + ~B + 1).
//
// state | meaning
// IDLE  | no operation open; only in_first beats are accepted as data
// RUN   | operation open; carry_q holds carry into the next word
module multiword_cla_adder_seq
    import multiword_adder_pkg::*;
#(
    parameter int MAX_WORDS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    multiword_cla_adder_seq_if.slave    bus
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_e            state_q, state_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic              out_last_q, out_last_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;

    logic              in_ready;
    logic              accept;
    logic              take;
    logic [CNT_W-1:0]  cnt_inc;
    logic [WORD_W-1:0] add_b;
    logic              add_cin;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

`ifdef MULTIWORD_CLA_ADDER_SEQ_SUB_EN
    logic              sub_q, sub_d;

    // Subtract is A + ~B + 1; the mode is latched from the first beat.
    always_comb begin
        logic sub_now;
        sub_now = bus.in_first ? bus.op_sub : sub_q;
        add_b   = sub_now ? ~bus.b : bus.b;
        add_cin = bus.in_first ? (bus.op_sub | bus.cin) : carry_q;
    end
`else
    always_comb begin
        add_b   = bus.b;
        add_cin = bus.in_first ? bus.cin : carry_q;
    end
`endif

    carry_lookahead_adder_64 u_cla (
        .a    (bus.a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        sum_d       = sum_q;
        out_last_d  = out_last_q;
        cout_d      = cout_q;
        err_d       = 1'b0;
        take        = 1'b0;
        cnt_inc     = '0;
`ifdef MULTIWORD_CLA_ADDER_SEQ_SUB_EN
        sub_d       = sub_q;
`endif
        if (accept) begin
            if (bus.in_first) begin
                // A first beat inside RUN abandons the open operation.
                take    = 1'b1;
                cnt_inc = CNT_W'(1);
                err_d   = (state_q == RUN);
`ifdef MULTIWORD_CLA_ADDER_SEQ_SUB_EN
                sub_d   = bus.op_sub;
`endif
            end else if (state_q == RUN) begin
                take    = 1'b1;
                cnt_inc = cnt_q + 1'b1;
            end else begin
                err_d   = 1'b1;
            end

            if (take) begin
                out_valid_d = 1'b1;
                sum_d       = add_sum;
                carry_d     = add_cout;
                if (bus.in_last || cnt_inc == MAX_CNT) begin
                    out_last_d = 1'b1;
                    cout_d     = add_cout;
                    state_d    = IDLE;
                    cnt_d      = '0;
                    if (!bus.in_last) err_d = 1'b1;
                end else begin
                    out_last_d = 1'b0;
                    cout_d     = 1'b0;
                    state_d    = RUN;
                    cnt_d      = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef MULTIWORD_CLA_ADDER_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            out_last_q  <= out_last_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
`ifdef MULTIWORD_CLA_ADDER_SEQ_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.cout      = cout_q;
    assign bus.err       = err_q;
endmodule

// File: doc/multiword_cla_adder_seq.md
Name: multiword_cla_adder_seq

Overview:
Sequential multi-word adder that streams N×64-bit operands one 64-bit word per beat, least-significant word first, through one carry_lookahead_adder_64 instance.
- Carry is chained between beats in a register.
- Sits upstream of the datapath consumers as the wide-integer add engine, fed by an operand streamer.
- Valid/ready handshake on input and output; output register is one entry deep.

Parameters:
- WORD_W, 64, width of one operand/sum word; fixed to match carry_lookahead_adder_64.
- MAX_WORDS, 16, maximum words per operation before forced termination.
- CNT_W, $clog2(MAX_WORDS+1), width of the beat counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_first  input  1  beat is least-significant word of a new operation.
- in_last  input  1  beat is most-significant word of the operation.
- a  input  WORD_W  operand A word.
- b  input  WORD_W  operand B word.
- cin  input  1  carry-in; used only on in_first beats.
- out_valid  output  1  sum word valid.
- out_ready  input  1  downstream accepts sum word.
- sum  output  WORD_W  sum word.
- out_last  output  1  sum word is final word of operation.
- cout  output  1  final carry-out; meaningful only when out_last=1, else 0.
- err  output  1  one-cycle protocol-error pulse.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, carry_q=0, cnt=0. Outputs: out_valid=0, sum=0, out_last=0, cout=0, err=0.
- Acceptance: accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational). Simultaneous pop and push is allowed, giving full throughput.
- Adder carry-in = in_first ? cin : carry_q. Adder is combinational; result is registered.
- Latency: exactly 1 cycle from accept to out_valid=1.
- Output hold: while out_valid && !out_ready, sum/out_last/cout are held stable and in_ready=0. out_valid clears on pop when there is no new accept.
- FSM states: IDLE, RUN.
- IDLE, accept with in_first=1: compute word; cnt=1; carry_q=adder cout. Go to RUN, or stay in IDLE if in_last=1 (single-word operation, out_last=1, cout=adder cout).
- IDLE, accept with in_first=0: beat dropped, no output, err=1 for one cycle.
- RUN, accept with in_first=0: carry from carry_q; cnt++; carry_q updated.
- RUN, accept with in_last=1: out_last=1, cout=adder cout, go to IDLE, cnt=0.
- RUN, accept with in_first=1 (restart): previous operation abandoned without a last word; err=1; new operation starts as in IDLE.
- Word-count limit: the beat that makes cnt==MAX_WORDS without in_last is forced out_last=1, cout=adder cout, err=1, then IDLE.
- Beats with in_first=in_last=1 are valid in either state. In RUN they also raise err (abandon rule).
- Reset mid-operation: partial operation discarded, pending output dropped, carry_q cleared.
- Arithmetic: modulo 2^WORD_W per word; carry exact across words.

Optional Feature:
- Macro MULTIWORD_CLA_ADDER_SEQ_SUB_EN.
- Defined: adds port op_sub (input, 1), sampled on in_first beats and held in a register for the operation. When op_sub=1:
  - adder b-input = ~b;
  - carry-in on the first beat = 1 (cin ignored);
  - final cout = 1 means no borrow.
- Undefined: port absent; add only.

Decomposition:
- Package multiword_adder_pkg: WORD_W constant, state enum type (IDLE, RUN).
- Sub-module: reuse the existing carry_lookahead_adder_64, instantiated once. No new sub-module.

Test Plan:
- Single word: a=0xE, b=0x1, cin=0, first=last=1 -> next cycle out_valid=1, sum=0xF, out_last=1, cout=0.
- Two words: (lo=FFFF_FFFF_FFFF_FFFF, hi=0) + (lo=1, hi=0) -> sums 0 then 1; out_last on beat 2; cout=0.
- Three words, all operand-A words = all-ones, B = 1,0,0 -> sums 0,0,0; final cout=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, sum stable. After release, every beat is delivered once, in order.
- Protocol errors:
  - beat with in_first=0 in IDLE -> dropped, err pulse, no out_valid;
  - MAX_WORDS=4 with 5 beats and no last -> beat 4 has out_last=1 and err pulse; beat 5 dropped with err.
- SUB_EN: 5 - 7 single word, op_sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0. 7 - 5 -> sum=2, cout=1.
